mux_arbitro_rr: RTL and testbench
=================================

Name: mux_arbitro_rr

Overview:
- Round-robin arbiter that shares one 8-bit 8:1 bus mux between 8 requesters.
- Grants one requester at a time as a one-hot GNT vector.
- Drives the mux select S with the binary index of the granted source.
- Limits each grant to HOLD_MAX cycles so no source can starve the others; sits directly in front of the mux select input.

Parameters:
HOLD_MAX, 4, maximum consecutive cycles a single grant may last; legal range 1..255
CNT_W, 8, width of the internal hold counter; must hold HOLD_MAX

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
REQ  input  8  request vector, REQ[i] high = source Ii wants the bus
GNT  output  8  registered one-hot grant, all zeros when idle
S  output  3  registered mux select = index of granted source
BUSY  output  1  registered, high while any grant is active
GRANT_END  output  1  registered one-cycle pulse on the cycle after a grant is released
LOCK  input  1  present only with MUX_ARB_LOCK_EN; extends the current grant

Behaviour:
- One clock (clk); reset is synchronous and active-high. While reset is high at a rising edge:
  - GNT=0, S=0, BUSY=0, GRANT_END=0.
  - Hold counter = 0.
  - Last-granted pointer LAST=7, so the first search starts at source 0.
  - State=IDLE.
- Reset asserted mid-grant takes effect at the next edge and overrides every other event.
- Search order: LAST+1, LAST+2, ..., LAST+8 (mod 8). The first index with REQ high wins. The current holder is therefore checked last.
- IDLE state:
  - GNT=0, BUSY=0; S holds its previous value so the mux output stays stable.
  - At an edge with REQ!=0: go to GRANT, set GNT[w]=1, S=w, BUSY=1, counter=1.
  - Latency from REQ sampled to GNT visible: 1 clock.
- GRANT state (holder c), evaluated at each edge:
  - Release condition: REQ[c]==0, or counter==HOLD_MAX.
  - No release: counter increments; GNT and S are unchanged.
  - Release with another request pending: set LAST=c, run the search, and grant winner w back-to-back with no idle cycle. Counter=1, GRANT_END=1 for one cycle, BUSY stays 1.
  - If c is the only requester after the counter expires, c is regranted back-to-back with counter=1, and GRANT_END pulses.
  - Release with REQ==0: set LAST=c, go to IDLE, GNT=0, BUSY=0, GRANT_END=1.
- GRANT_END is 0 on every cycle where no release happened at the preceding edge.
- A requester that drops REQ loses the grant at the next edge; the bus is never granted to a source whose REQ was low at the deciding edge.
- GNT is always one-hot or zero. S always equals the index of the set GNT bit while BUSY=1.
- The hold counter never exceeds HOLD_MAX. Any HOLD_MAX outside 1..255 is a configuration error; the implementation flags it with a simulation-time $error.

Optional Feature:
- Macro: MUX_ARB_LOCK_EN.
- Defined:
  - LOCK port exists.
  - While LOCK=1 and REQ[c]=1, the HOLD_MAX expiry is ignored; the counter saturates at HOLD_MAX.
  - Release happens only when REQ[c] drops, or at the first edge with LOCK=0 and counter==HOLD_MAX.
  - LOCK is ignored in IDLE.
- Not defined: no LOCK port; grants always end at HOLD_MAX.

Test Plan:
- Reset, then REQ=8'h00 for 5 cycles -> GNT=0, S=0, BUSY=0, GRANT_END=0 throughout.
- REQ=8'b0000_0100 held, HOLD_MAX=4 -> GNT=8'h04 and S=2 one cycle later. At the 4-cycle expiry GRANT_END pulses and source 2 is regranted back-to-back with BUSY=1.
- REQ=8'hFF held, HOLD_MAX=2 -> grants rotate through S=0,1,2,...,7,0, each lasting 2 cycles, with GRANT_END pulsing at every handover.
- Holder 3 active, REQ drops to 8'b1000_0001 -> next grant goes to S=7, not 0 (search starts at 4).
- Reset asserted during a grant to source 5 -> after that edge GNT=0, BUSY=0, S=0. With REQ=8'b0010_0001, the next grant goes to source 0 (LAST=7).
- With MUX_ARB_LOCK_EN, LOCK=1 and REQ=8'h03 holder 0, HOLD_MAX=2 -> source 0 keeps the grant for 6 cycles. Dropping LOCK causes a handover to source 1 at the next edge.

Source files
------------

// File: rtl/mux_arbitro_rr.sv
// mux_arbitro_rr: round-robin arbiter driving the select of an 8-bit 8:1 bus mux.
// One-hot grant GNT plus binary select S; each grant lasts at most HOLD_MAX cycles.
// Optional feature macro: MUX_ARB_LOCK_EN adds a LOCK input that stretches the
// current grant past HOLD_MAX for as long as LOCK and the holder's request stay high.
module mux_arbitro_rr #(
   parameter int HOLD_MAX = 4,
   parameter int CNT_W    = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] REQ,
`ifdef MUX_ARB_LOCK_EN
   input  logic       LOCK,
`endif
   output logic [7:0] GNT,
   output logic [2:0] S,
   output logic       BUSY,
   output logic       GRANT_END
);

   // Configuration sanity: HOLD_MAX must be 1..255 and fit in the hold counter.
   if (HOLD_MAX < 1 || HOLD_MAX > 255 || HOLD_MAX > ((64'd1 << CNT_W) - 64'd1)) begin : g_cfg_err
      $error("mux_arbitro_rr: HOLD_MAX=%0d illegal for CNT_W=%0d", HOLD_MAX, CNT_W);
   end

   typedef enum logic {IDLE, GRANT} state_t;

   localparam logic [CNT_W-1:0] HOLD_C = CNT_W'(HOLD_MAX);

   state_t           state;
   logic [2:0]       last;
   logic [CNT_W-1:0] cnt;

   logic [2:0]       search_from;
   logic             found;
   logic [2:0]       winner;
   logic             hold_hit;
   logic             release_now;
   logic             lock_hold;

   // Scan LAST+1 .. LAST+8; iterating backwards lets the closest hit overwrite.
   function automatic logic [3:0] rr_pick(input logic [7:0] req, input logic [2:0] from);
      logic [2:0] idx;
      logic [3:0] res;
      res = 4'd0;
      for (int k = 8; k >= 1; k--) begin
         idx = from + 3'(k);
         if (req[idx]) res = {1'b1, idx};
      end
      return res;
   endfunction

   // Search start and release decision; on release the holder becomes LAST,
   // so the holder itself is examined last.
   always_comb begin
      search_from = (state == GRANT) ? S : last;
      {found, winner} = rr_pick(REQ, search_from);
      hold_hit = (cnt == HOLD_C);
`ifdef MUX_ARB_LOCK_EN
      lock_hold = LOCK;
`else
      lock_hold = 1'b0;
`endif
      release_now = !REQ[S] || (hold_hit && !lock_hold);
   end

   // Arbiter FSM with registered outputs; reset overrides every other event.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         GNT       <= 8'd0;
         S         <= 3'd0;
         BUSY      <= 1'b0;
         GRANT_END <= 1'b0;
         cnt       <= '0;
         last      <= 3'd7;
      end else begin
         GRANT_END <= 1'b0;
         case (state)
            IDLE: begin
               // S keeps its old value while idle so the mux output stays put.
               if (found) begin
                  state <= GRANT;
                  GNT   <= 8'd1 << winner;
                  S     <= winner;
                  BUSY  <= 1'b1;
                  cnt   <= CNT_W'(1);
               end
            end
            GRANT: begin
               if (release_now) begin
                  last      <= S;
                  GRANT_END <= 1'b1;
                  if (found) begin
                     // Back-to-back handover (possibly to the same holder).
                     GNT  <= 8'd1 << winner;
                     S    <= winner;
                     cnt  <= CNT_W'(1);
                  end else begin
                     state <= IDLE;
                     GNT   <= 8'd0;
                     BUSY  <= 1'b0;
                     cnt   <= '0;
                  end
               end else begin
                  // Saturate at HOLD_MAX; only reachable while a lock stretches the grant.
                  if (!hold_hit) cnt <= cnt + CNT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mux_arbitro_rr.sv
// Directed self-checking bench for mux_arbitro_rr.
// Two instances share stimulus: u4 (HOLD_MAX=4) and u2 (HOLD_MAX=2).
module tb_mux_arbitro_rr;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] req;
`ifdef MUX_ARB_LOCK_EN
   logic       lock;
`endif
   logic [7:0] gnt4, gnt2;
   logic [2:0] s4, s2;
   logic       busy4, busy2, ge4, ge2;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mux_arbitro_rr #(.HOLD_MAX(4), .CNT_W(8)) u4 (
      .clk(clk), .reset(reset), .REQ(req),
`ifdef MUX_ARB_LOCK_EN
      .LOCK(lock),
`endif
      .GNT(gnt4), .S(s4), .BUSY(busy4), .GRANT_END(ge4));

   mux_arbitro_rr #(.HOLD_MAX(2), .CNT_W(8)) u2 (
      .clk(clk), .reset(reset), .REQ(req),
`ifdef MUX_ARB_LOCK_EN
      .LOCK(lock),
`endif
      .GNT(gnt2), .S(s2), .BUSY(busy2), .GRANT_END(ge2));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and land 1 time unit after it for sampling.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Full output check of one instance.
   task automatic chk4(input string tag, input logic [7:0] g, input logic [2:0] s,
                       input logic b, input logic e);
      chk({tag, ".gnt4"}, 32'(gnt4), 32'(g));
      chk({tag, ".s4"},   32'(s4),   32'(s));
      chk({tag, ".busy4"},32'(busy4),32'(b));
      chk({tag, ".ge4"},  32'(ge4),  32'(e));
   endtask

   task automatic chk2(input string tag, input logic [7:0] g, input logic [2:0] s,
                       input logic b, input logic e);
      chk({tag, ".gnt2"}, 32'(gnt2), 32'(g));
      chk({tag, ".s2"},   32'(s2),   32'(s));
      chk({tag, ".busy2"},32'(busy2),32'(b));
      chk({tag, ".ge2"},  32'(ge2),  32'(e));
   endtask

   initial begin
      reset = 1'b1;
      req   = 8'h00;
`ifdef MUX_ARB_LOCK_EN
      lock  = 1'b0;
`endif
      #2;

      // Reset state, then idle with no requests.
      step();
      chk4("rst", 8'h00, 3'd0, 1'b0, 1'b0);
      chk2("rst", 8'h00, 3'd0, 1'b0, 1'b0);
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         chk4("idle", 8'h00, 3'd0, 1'b0, 1'b0);
      end

      // Single requester 2, HOLD_MAX=4: grant, expiry, back-to-back regrant.
      req = 8'b0000_0100;
      step();
      chk4("sole.grant", 8'h04, 3'd2, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk4("sole.hold", 8'h04, 3'd2, 1'b1, 1'b0);
      end
      step();
      chk4("sole.expire", 8'h04, 3'd2, 1'b1, 1'b1);
      step();
      chk4("sole.after", 8'h04, 3'd2, 1'b1, 1'b0);

      // Drop request: release to idle, S holds 2.
      req = 8'h00;
      step();
      chk4("drop.idle", 8'h00, 3'd2, 1'b0, 1'b1);
      step();
      chk4("drop.idle2", 8'h00, 3'd2, 1'b0, 1'b0);

      // All requesting, HOLD_MAX=2: rotate 0..7,0, two cycles each.
      reset = 1'b1;
      step();
      reset = 1'b0;
      req = 8'hFF;
      for (int k = 0; k < 9; k++) begin
         step();
         chk2("rot.first", 8'd1 << (k % 8), 3'(k % 8), 1'b1, (k > 0));
         step();
         chk2("rot.second", 8'd1 << (k % 8), 3'(k % 8), 1'b1, 1'b0);
      end

      // Holder 3 drops; 0 and 7 pending: search starts at 4 so 7 wins.
      reset = 1'b1;
      step();
      reset = 1'b0;
      req = 8'b0000_1000;
      step();
      chk4("h3.grant", 8'h08, 3'd3, 1'b1, 1'b0);
      req = 8'b1000_0001;
      step();
      chk4("h3.handover", 8'h80, 3'd7, 1'b1, 1'b1);

      // Reset mid-grant to 5, then LAST=7 means source 0 wins.
      reset = 1'b1;
      step();
      reset = 1'b0;
      req = 8'b0010_0000;
      step();
      chk4("r5.grant", 8'h20, 3'd5, 1'b1, 1'b0);
      step();
      chk4("r5.hold", 8'h20, 3'd5, 1'b1, 1'b0);
      reset = 1'b1;
      step();
      chk4("r5.reset", 8'h00, 3'd0, 1'b0, 1'b0);
      reset = 1'b0;
      req = 8'b0010_0001;
      step();
      chk4("r5.regrant", 8'h01, 3'd0, 1'b1, 1'b0);

`ifdef MUX_ARB_LOCK_EN
      // LOCK stretches holder 0 beyond HOLD_MAX=2; dropping LOCK hands over to 1.
      reset = 1'b1;
      step();
      reset = 1'b0;
      lock = 1'b1;
      req  = 8'h03;
      for (int i = 0; i < 6; i++) begin
         step();
         chk2("lock.hold", 8'h01, 3'd0, 1'b1, 1'b0);
      end
      lock = 1'b0;
      step();
      chk2("lock.release", 8'h02, 3'd1, 1'b1, 1'b1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
